// File: rtl/demux1_4_buf.sv
// demux1_4_buf: 1-to-4 valid/ready demux with one stall stage and four holding registers; ports clk, rst, switch, in_data, in_valid, in_ready, o_1..o_4, out_valid, out_ready, xfer_cnt
module demux1_4_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] switch,
  input  logic [4:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] o_1,
  output logic [4:0] o_2,
  output logic [4:0] o_3,
  output logic [4:0] o_4,
  output logic [3:0] out_valid,
  input  logic [3:0] out_ready,
  output logic [7:0] xfer_cnt
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t state, state_nx;
  logic [4:0] stage_data, wr_data;
  logic [1:0] stage_sel, wr_sel;
  logic [4:0] ch [4];
  logic [3:0] free, wr_vec, valid_nx;
  logic       accept, wr_en, cap;
  assign in_ready = state == IDLE;
  assign free     = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign {o_4, o_3, o_2, o_1} = {ch[3], ch[2], ch[1], ch[0]};
  always_comb begin
    wr_sel   = in_ready ? switch : stage_sel;
    wr_data  = in_ready ? in_data : stage_data;
    wr_en    = in_ready ? accept & free[switch] : free[stage_sel];
    cap      = accept & ~free[switch];
    state_nx = in_ready ? (cap ? STALL : IDLE) : (wr_en ? IDLE : STALL);
    wr_vec   = wr_en ? 4'b0001 << wr_sel : 4'b0000;
    valid_nx = wr_vec | (out_valid & ~out_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stage_data <= '0;
      stage_sel  <= '0;
      out_valid  <= '0;
      xfer_cnt   <= '0;
      ch         <= '{default: '0};
    end else begin
      state     <= state_nx;
      out_valid <= valid_nx;
      if (cap) begin
        stage_data <= in_data;
        stage_sel  <= switch;
      end
      if (accept) xfer_cnt <= xfer_cnt + 8'd1;
      for (int k = 0; k < 4; k++)
        if (wr_vec[k]) ch[k] <= wr_data;
    end
  end
endmodule
